// File: rtl/piso_frame_pkg.sv
// Shared constants for the PISO UART transmit framer.
//   START_BIT / STOP_BIT : frame delimiters loaded at the two chain ends
//   RESET_BIT            : value every stage takes on reset (line mark/idle)
//   DEFAULT_DATA_WIDTH   : default payload width
//   frame_width()        : total stage count for a given payload width
package piso_frame_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic RESET_BIT = 1'b1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Payload plus one start and one stop bit.
  function automatic int unsigned frame_width(input int unsigned data_width);
    return data_width + 32'd2;
  endfunction

endpackage

// File: rtl/piso_frame_shift_register_mux_dff_stage.sv
// One shift-chain cell: 2:1 load/shift mux feeding a D flip-flop.
// Ports:
//   pulse    in  clock (baud tick), rising edge
//   reset    in  synchronous active-high reset, forces q to RESET_BIT
//   enable   in  1 = take load_in, 0 = take shift_in
//   shift_in in  output of the previous stage (or fill bit for stage 0)
//   load_in  in  parallel frame bit for this stage
//   q        out registered stage value
module mux_dff_stage
  import piso_frame_pkg::*;
(
  input  logic pulse,
  input  logic reset,
  input  logic enable,
  input  logic shift_in,
  input  logic load_in,
  output logic q
);

  logic d_c;

  // Load/shift select.
  always_comb begin
    d_c = shift_in;
    if (enable) begin
      d_c = load_in;
    end
  end

  // Stage flop; reset takes priority over load and shift.
  always_ff @(posedge pulse) begin
    if (reset) begin
      q <= RESET_BIT;
    end else begin
      q <= d_c;
    end
  end

endmodule

// File: rtl/piso_frame_shift_register.sv
// Parallel-in/serial-out UART transmit framer. On a load edge the chain
// captures {stop, payload reversed, start}; each shift edge then moves the
// frame one stage toward q_out, so the line sends start, TxData[0] ..
// TxData[DATA_WIDTH-1], stop, then the fill bit.
// Optional feature: define PISO_IDLE_FILL_EN to shift in ones (idle mark)
// behind the stop bit; otherwise zeros are shifted in (legacy behaviour).
// Ports:
//   pulse   in  clock (baud tick)
//   reset   in  synchronous active-high reset, line goes to mark (1)
//   enable  in  1 = parallel load of a frame, 0 = shift
//   TxData  in  payload, bit 0 transmitted first
//   q_out   out registered serial line
module piso_frame_shift_register
  import piso_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  pulse,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] TxData,
  output logic                  q_out
);

  localparam int unsigned FRAME_WIDTH = frame_width(DATA_WIDTH);

`ifdef PISO_IDLE_FILL_EN
  localparam logic FILL_BIT = 1'b1;
`else
  localparam logic FILL_BIT = 1'b0;
`endif

  logic [FRAME_WIDTH-1:0] stage_q;
  logic [FRAME_WIDTH-1:0] load_vec;
  logic [FRAME_WIDTH-1:0] shift_vec;

  // Frame image: stop at the input end, start at the output end, payload
  // reversed between them so bit 0 leaves first.
  always_comb begin
    load_vec                = '0;
    load_vec[0]             = STOP_BIT;
    load_vec[FRAME_WIDTH-1] = START_BIT;
    for (int unsigned j = 1; j <= DATA_WIDTH; j++) begin
      load_vec[j] = TxData[DATA_WIDTH-j];
    end
  end

  // Each stage shifts from its lower neighbour; stage 0 takes the fill bit.
  always_comb begin
    shift_vec    = '0;
    shift_vec[0] = FILL_BIT;
    for (int unsigned i = 1; i < FRAME_WIDTH; i++) begin
      shift_vec[i] = stage_q[i-1];
    end
  end

  for (genvar g = 0; g < FRAME_WIDTH; g++) begin : g_stage
    mux_dff_stage u_stage (
      .pulse    (pulse),
      .reset    (reset),
      .enable   (enable),
      .shift_in (shift_vec[g]),
      .load_in  (load_vec[g]),
      .q        (stage_q[g])
    );
  end

  assign q_out = stage_q[FRAME_WIDTH-1];

endmodule

// File: tb/tb_piso_frame_shift_register.sv
// Directed self-checking bench for piso_frame_shift_register (DATA_WIDTH=8).
// Build with the same PISO_IDLE_FILL_EN setting as the RTL.
module tb_piso_frame_shift_register;

  localparam int unsigned DW = 8;

`ifdef PISO_IDLE_FILL_EN
  localparam logic EXP_FILL = 1'b1;
`else
  localparam logic EXP_FILL = 1'b0;
`endif

  logic          pulse;
  logic          reset;
  logic          enable;
  logic [DW-1:0] tx_data;
  logic          q_out;

  int errors = 0;
  int checks = 0;

  piso_frame_shift_register #(.DATA_WIDTH(DW)) dut (
    .pulse  (pulse),
    .reset  (reset),
    .enable (enable),
    .TxData (tx_data),
    .q_out  (q_out)
  );

  initial pulse = 1'b0;
  always #5 pulse = ~pulse;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic [DW-1:0] data);
    @(negedge pulse);
    reset   = rst;
    enable  = en;
    tx_data = data;
    @(posedge pulse);
    #1;
  endtask

  // Shift out one frame's data and stop bits after a load edge. TxData is
  // scrambled during shifts; it must not affect the serial stream.
  task automatic shift_frame(input string tag, input logic [DW-1:0] data);
    logic [DW-1:0] d;
    d = data;
    for (int k = 1; k <= int'(DW); k++) begin
      step(1'b0, 1'b0, DW'($urandom));
      check($sformatf("%s_bit%0d", tag, k - 1), q_out, d[k-1]);
    end
    step(1'b0, 1'b0, DW'($urandom));
    check($sformatf("%s_stop", tag), q_out, 1'b1);
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    tx_data = '0;

    // Reset: line at mark, reset beats a simultaneous load.
    step(1'b1, 1'b0, 8'h00);
    check("reset_idle", q_out, 1'b1);
    step(1'b1, 1'b1, 8'h00);
    check("reset_over_load", q_out, 1'b1);
    step(1'b1, 1'b1, 8'h00);
    check("reset_over_load2", q_out, 1'b1);

    // Load/shift 0xAA then fill bits behind the stop.
    step(1'b0, 1'b1, 8'hAA);
    check("aa_start", q_out, 1'b0);
    shift_frame("aa", 8'hAA);
    for (int k = 10; k <= 16; k++) begin
      step(1'b0, 1'b0, 8'h00);
      check($sformatf("aa_fill%0d", k), q_out, EXP_FILL);
    end

    // Back-to-back frames 0x01 then 0xFF.
    step(1'b0, 1'b1, 8'h01);
    check("b2b_01_start", q_out, 1'b0);
    shift_frame("b2b_01", 8'h01);
    step(1'b0, 1'b1, 8'hFF);
    check("b2b_ff_start", q_out, 1'b0);
    shift_frame("b2b_ff", 8'hFF);

    // Reset mid-frame: frame discarded, chain holds all ones.
    step(1'b0, 1'b1, 8'h55);
    check("rst_mid_start", q_out, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("rst_mid_b0", q_out, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("rst_mid_b1", q_out, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("rst_mid_b2", q_out, 1'b1);
    step(1'b1, 1'b0, 8'h00);
    check("rst_mid_reset", q_out, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 8'h00);
      check($sformatf("rst_mid_shift%0d", k), q_out, (k <= 9) ? 1'b1 : EXP_FILL);
    end

    // Held load: reloads every edge, last TxData wins.
    step(1'b0, 1'b1, 8'h11);
    check("held_0", q_out, 1'b0);
    step(1'b0, 1'b1, 8'h22);
    check("held_1", q_out, 1'b0);
    step(1'b0, 1'b1, 8'h33);
    check("held_2", q_out, 1'b0);
    step(1'b0, 1'b1, 8'hC3);
    check("held_3", q_out, 1'b0);
    shift_frame("held_c3", 8'hC3);

    // Mid-frame reload aborts 0x0F and restarts with 0xF0.
    step(1'b0, 1'b1, 8'h0F);
    check("reload_0f_start", q_out, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 8'h00);
      check($sformatf("reload_0f_bit%0d", k), q_out, 1'b1);
    end
    step(1'b0, 1'b1, 8'hF0);
    check("reload_f0_start", q_out, 1'b0);
    shift_frame("reload_f0", 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
